// File: rtl/div_pkg.sv
`default_nettype none
// ==========================================================================
// Module : div_pkg
// Brief  : Shared width, counter sizing and FSM encoding for the divide path.
// Rev    : 1.0  initial release
// ==========================================================================
package div_pkg;

  localparam int DIV_WIDTH = 16;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ==========================================================================
// Module : div_step
// Brief  : One restoring-division step built from a ripple of subtractor cells.
// Rev    : 1.0  initial release
// ==========================================================================
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] w_minuend;
  logic [WIDTH:0] w_subtrahend;
  logic [WIDTH:0] w_diff;
  logic [WIDTH:1] w_borrow;

  assign w_minuend    = {partial_rem, next_bit};
  assign w_subtrahend = {1'b0, divisor};

  for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
    if (i == 0) begin : g_half
      assign w_diff[i]       = w_minuend[i] ^ w_subtrahend[i];
      assign w_borrow[i + 1] = ~w_minuend[i] & w_subtrahend[i];
    end else if (i == WIDTH) begin : g_msb
      // Sign of the trial difference; no borrow-out is needed past this cell.
      assign w_diff[i] = w_minuend[i] ^ w_subtrahend[i] ^ w_borrow[i];
    end else begin : g_full
      assign w_diff[i]       = w_minuend[i] ^ w_subtrahend[i] ^ w_borrow[i];
      assign w_borrow[i + 1] = (~w_minuend[i] & w_subtrahend[i]) |
                               (~(w_minuend[i] ^ w_subtrahend[i]) & w_borrow[i]);
    end
  end

  assign q_bit = ~w_diff[WIDTH];

  // Either choice is below the divisor, so the top bit is always zero.
  assign next_rem = q_bit ? w_diff[WIDTH-1:0] : w_minuend[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_divider16.sv
`default_nettype none
// ==========================================================================
// Module : seq_divider16
// Brief  : Iterative restoring unsigned divider, one quotient bit per clock.
// Rev    : 1.0  initial release
// ==========================================================================
module seq_divider16
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_last;
  logic             w_zero_div;
  logic             w_q_bit;
  logic [WIDTH-1:0] w_next_rem;
  logic [WIDTH-1:0] w_next_dq;

  assign w_zero_div = (divisor == '0);

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .partial_rem (r_rem),
    .next_bit    (r_dq[WIDTH-1]),
    .divisor     (r_divisor),
    .next_rem    (w_next_rem),
    .q_bit       (w_q_bit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign w_next_dq = {r_dq[WIDTH-2:0], w_q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_zero_div ? DONE : RUN;
        end
      end
      RUN: begin
        if (r_count == C_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_zero_div ? DONE : RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count       <= '0;
      r_dq          <= '0;
      r_rem         <= '0;
      r_divisor     <= '0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == RUN);
      r_done <= (w_state_nxt == DONE);
      if (w_accept) begin
        r_count   <= '0;
        r_rem     <= '0;
        r_dq      <= dividend;
        r_divisor <= divisor;
        if (w_zero_div) begin
          r_quotient    <= '1;
          r_remainder   <= dividend;
          r_div_by_zero <= 1'b1;
        end else begin
          r_div_by_zero <= 1'b0;
        end
      end else if (r_state == RUN) begin
        r_count <= r_count + 1'b1;
        r_rem   <= w_next_rem;
        r_dq    <= w_next_dq;
        if (w_last) begin
          r_quotient  <= w_next_dq;
          r_remainder <= w_next_rem;
        end
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider16.sv
`default_nettype none
// ==========================================================================
// Module : tb_seq_divider16
// Brief  : Directed-vector and corner-sequence bench for seq_divider16.
// Rev    : 1.0  initial release
// ==========================================================================
module tb_seq_divider16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int n_err;
  int n_chk;

  seq_divider16 #(
    .WIDTH (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dbz;
    int          lat;
    int          busy_n;
  } vec_t;

  vec_t vecs[14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
  endtask

  // Starts just after the accepting edge; returns edges until done is seen.
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      step();
      lat++;
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  initial begin
    int lat;
    int bn;
    int cnt;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] recon;

    n_err    = 0;
    n_chk    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    vecs[0]  = '{16'd100,   16'd7,      16'd14,     16'd2,      1'b0, 16, 16};
    vecs[1]  = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,      1'b0, 16, 16};
    vecs[2]  = '{16'd3,     16'd10,     16'd0,      16'd3,      1'b0, 16, 16};
    vecs[3]  = '{16'd5,     16'd0,      16'hFFFF,   16'd5,      1'b1, 0,  0};
    vecs[4]  = '{16'd9,     16'd3,      16'd3,      16'd0,      1'b0, 16, 16};
    vecs[5]  = '{16'hABCD,  16'h0123,   16'h0097,   16'h0028,   1'b0, 16, 16};
    vecs[6]  = '{16'd7,     16'd7,      16'd1,      16'd0,      1'b0, 16, 16};
    vecs[7]  = '{16'd0,     16'd5,      16'd0,      16'd0,      1'b0, 16, 16};
    vecs[8]  = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,      1'b0, 16, 16};
    vecs[9]  = '{16'd1000,  16'd3,      16'd333,    16'd1,      1'b0, 16, 16};
    vecs[10] = '{16'h8000,  16'h8001,   16'd0,      16'h8000,   1'b0, 16, 16};
    vecs[11] = '{16'hFFFF,  16'h0100,   16'h00FF,   16'h00FF,   1'b0, 16, 16};
    vecs[12] = '{16'd0,     16'd0,      16'hFFFF,   16'd0,      1'b1, 0,  0};
    vecs[13] = '{16'd12345, 16'd123,    16'd100,    16'd45,     1'b0, 16, 16};

    step();
    step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_quot", 32'(quotient), 32'd0);
    chk("reset_rem",  32'(remainder), 32'd0);
    chk("reset_dbz",  32'(div_by_zero), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].a, vecs[i].b);
      wait_done(lat, bn);
      chk($sformatf("v%0d_quot", i), 32'(quotient), 32'(vecs[i].q));
      chk($sformatf("v%0d_rem", i), 32'(remainder), 32'(vecs[i].r));
      chk($sformatf("v%0d_dbz", i), 32'(div_by_zero), 32'(vecs[i].dbz));
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy", i), 32'(bn), 32'(vecs[i].busy_n));
      step();
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      chk($sformatf("v%0d_hold_q", i), 32'(quotient), 32'(vecs[i].q));
    end

    // Back-to-back: new start presented during the done cycle.
    issue(16'hFFFF, 16'd1);
    wait_done(lat, bn);
    chk("b2b_first_q", 32'(quotient), 32'hFFFF);
    issue(16'd3, 16'd10);
    chk("b2b_accept_busy", 32'(busy), 32'd1);
    chk("b2b_hold_q", 32'(quotient), 32'hFFFF);
    wait_done(lat, bn);
    chk("b2b_lat", 32'(lat), 32'd16);
    chk("b2b_q", 32'(quotient), 32'd0);
    chk("b2b_r", 32'(remainder), 32'd3);
    step();

    // Divide by zero, then a normal divide clears the flag at acceptance.
    issue(16'd5, 16'd0);
    chk("dbz_busy_e0", 32'(busy), 32'd0);
    chk("dbz_done_e0", 32'(done), 32'd1);
    step();
    chk("dbz_hold_flag", 32'(div_by_zero), 32'd1);
    chk("dbz_hold_rem", 32'(remainder), 32'd5);
    issue(16'd9, 16'd3);
    chk("dbz_clear_e0", 32'(div_by_zero), 32'd0);
    wait_done(lat, bn);
    chk("dbz_next_q", 32'(quotient), 32'd3);
    chk("dbz_next_r", 32'(remainder), 32'd0);
    step();

    // Start during RUN must be ignored.
    issue(16'd100, 16'd7);
    for (int k = 0; k < 4; k++) step();
    issue(16'd50, 16'd5);
    wait_done(lat, bn);
    chk("ign_lat", 32'(lat + 5), 32'd16);
    chk("ign_q", 32'(quotient), 32'd14);
    chk("ign_r", 32'(remainder), 32'd2);
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      step();
      if (done) cnt++;
    end
    chk("ign_single_done", 32'(cnt), 32'd0);

    // Asynchronous reset mid-run.
    issue(16'hABCD, 16'h0123);
    for (int k = 0; k < 7; k++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outputs", {busy, done, div_by_zero, quotient, remainder}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done || busy) cnt++;
    end
    chk("arst_no_done", 32'(cnt), 32'd0);
    issue(16'hABCD, 16'h0123);
    wait_done(lat, bn);
    chk("arst_retry_q", 32'(quotient), 32'h0097);
    chk("arst_retry_r", 32'(remainder), 32'h0028);
    step();

    // Randomised operand pairs checked against the division identity.
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      case (i % 4)
        0:       b = a;
        1:       b = a + 16'($urandom_range(1, 255));
        default: b = 16'($urandom_range(1, 65535) >> $urandom_range(0, 15));
      endcase
      if (b == 16'd0) b = 16'd1;
      issue(a, b);
      wait_done(lat, bn);
      recon = 32'(quotient) * 32'(b) + 32'(remainder);
      if (recon !== 32'(a) || remainder >= b) begin
        chk($sformatf("rand%0d_%0h_div_%0h", i, a, b), {quotient, remainder},
            {16'(a / b), 16'(a % b)});
      end else begin
        n_chk++;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_divider16.md
# seq_divider16

Iterative restoring unsigned divider that complements the Dadda 16x16 multiplier datapath: it computes quotient and remainder of two WIDTH-bit unsigned operands, producing one quotient bit per clock. It sits beside the multiplier as the arithmetic unit's divide path. It trades area for latency, reusing a single subtract/compare stage for every bit.

## Interface
- WIDTH, 16, operand/result width in bits (must be >= 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse; sampled only in IDLE or DONE
- dividend  input  WIDTH  unsigned dividend, captured on accepted start
- divisor  input  WIDTH  unsigned divisor, captured on accepted start
- busy  output  1  high while iterating (state RUN)
- done  output  1  one-cycle pulse, results valid
- quotient  output  WIDTH  result quotient, held until next accepted start
- remainder  output  WIDTH  result remainder, held until next accepted start
- div_by_zero  output  1  set with done when divisor was 0; held with results

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE.
- IDLE/DONE + start:
  - divisor != 0 -> capture operands, clear partial remainder (WIDTH+1 bits), clear count -> RUN.
  - divisor == 0 -> quotient = all ones, remainder = dividend, div_by_zero = 1 -> DONE.
- RUN, each cycle (restoring step):
  - trial = {rem[WIDTH-1:0], dq[WIDTH-1]} - {1'b0, divisor}.
  - trial MSB = 0 -> rem = trial, shift 1 into quotient LSB.
  - Otherwise -> rem = {rem[WIDTH-1:0], dq[WIDTH-1]}, shift 0 into quotient LSB.
  - dq shifts left by one each step.
  - count increments; after step WIDTH (count == WIDTH-1 at the edge) -> DONE.
- DONE lasts exactly one cycle; no start -> IDLE.
- Outputs:
  - quotient/remainder/div_by_zero update only at the edge entering DONE, then hold through IDLE.
  - div_by_zero clears when a nonzero-divisor start is accepted.
- start during RUN is ignored: no capture, no restart, no error flag.
- start in the DONE cycle is accepted (back-to-back operation).
- Operand inputs are don't-care except at the accepting edge.
- Reset asserted at any time, including mid-RUN: operation aborted immediately, no done pulse, state IDLE.

## Timing
- Reset values: busy 0, done 0, quotient 0, remainder 0, div_by_zero 0, state IDLE, count 0.
- Normal divide: start accepted at edge E0.
  - busy = 1 during cycles after E0 through E(WIDTH).
  - done = 1 for the single cycle after E(WIDTH).
  - Latency WIDTH edges (16 for default).
- Divide by zero: done = 1 in the cycle after E0 (latency 1), busy never asserted.
- Throughput: one result per WIDTH+1 cycles without idle gaps, since start is accepted while done is high.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package div_pkg:
  - DIV_WIDTH = 16.
  - State enum div_state_t {IDLE, RUN, DONE}.
  - Count width $clog2(DIV_WIDTH).
- Sub-module div_step (combinational, WIDTH-parameterised):
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Built as a ripple subtractor of half/full subtractor cells, mirroring the multiplier's adder-cell style.
- Top level holds FSM, counter, dq/rem/quotient registers and output registers.

## Test plan
- dividend 100, divisor 7, start at E0 -> done only in cycle after E16; quotient 14, remainder 2; busy high exactly 16 cycles.
- dividend 0xFFFF, divisor 1 -> quotient 0xFFFF, remainder 0. Then dividend 3, divisor 10 issued in the done cycle -> accepted; quotient 0, remainder 3 after 16 more edges.
- dividend 5, divisor 0 -> done in cycle after E0; quotient 0xFFFF, remainder 5, div_by_zero 1, busy never high. Next start 9/3 -> div_by_zero 0 from E0; quotient 3, remainder 0.
- start pulsed at E5 with 50/5 during a 100/7 run -> ignored; single done at E16 with 14/2.
- rst_n low at E8 of a 0xABCD/0x0123 divide -> all outputs 0 asynchronously, no done. After release, 0xABCD/0x0123 -> quotient 0x0097, remainder 0x0028.
- Randomised 1000 operand pairs including divisor > dividend and divisor == dividend -> quotient*divisor + remainder == dividend and remainder < divisor.
